rs_syndrome_ctrl: RTL and testbench



---
 rtl/rs_syndrome_ctrl_if.sv | 43 ++++
 rtl/rs_syndrome_ctrl.sv | 99 +++++++++
 tb/tb_rs_syndrome_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_syndrome_ctrl_if.sv
// Purpose: bundles the beat input, slice broadcast and syndrome output buses of rs_syndrome_ctrl.
// Latency: none, wires only.
// Backpressure: in_ready / out_ready carry the handshakes; the slice bus has no stall.
// Ports: in_* (framer beats), slc_* (slice broadcast and accumulators), out_* (syndrome vector), frame_err.
// Modports: slave = controller side, master = environment (framer, slices, solver).
interface rs_syndrome_ctrl_if #(
  parameter int NSYN = 16
);
  logic [127:0]      in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [127:0]      slc_data;
  logic              slc_valid;
  logic [3:0]        slc_beat;
  logic              slc_first;
  logic [NSYN*8-1:0] slc_syn;
  logic [NSYN*8-1:0] out_syn;
  logic              out_zero;
  logic              out_valid;
  logic              out_ready;
  logic              frame_err;

  modport slave (
    input  in_data, in_valid, in_last,
    output in_ready,
    output slc_data, slc_valid, slc_beat, slc_first,
    input  slc_syn,
    output out_syn, out_zero, out_valid,
    input  out_ready,
    output frame_err
  );

  modport master (
    output in_data, in_valid, in_last,
    input  in_ready,
    input  slc_data, slc_valid, slc_beat, slc_first,
    output slc_syn,
    input  out_syn, out_zero, out_valid,
    output out_ready,
    input  frame_err
  );
endinterface

// File: rtl/rs_syndrome_ctrl.sv
// Purpose: sequences 128-bit codeword beats into the RS syndrome slices and captures the syndrome vector.
// Latency: final beat accepted at edge t -> capture cycle t+1 -> out_valid from cycle t+2; 17 cycles/codeword.
// Backpressure: only the final beat waits for a free (or draining) output register; other beats never stall.
// Ports: clk, rst (sync, active-high), bus (rs_syndrome_ctrl_if.slave): in_* beats, slc_* slice bus,
//        out_* syndrome vector + error-free flag, frame_err pulse.
// Option: define RS_SYN_FRAME_CHECK_EN to check in_last against the beat count and drop misframed codewords.
module rs_syndrome_ctrl #(
  parameter int NSYN  = 16,
  parameter int BEATS = 16
) (
  input logic               clk,
  input logic               rst,
  rs_syndrome_ctrl_if.slave bus
);

  typedef enum logic {
    ACCUM = 1'b0,
    CAPT  = 1'b1
  } state_t;

  localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);

  state_t            state;
  logic [3:0]        beat;
  logic [NSYN*8-1:0] out_syn_q;
  logic              out_zero_q;
  logic              out_valid_q;
  logic              frame_err_q;

  logic at_last;
  logic in_ready_c;
  logic accept;
  logic frame_bad;

  assign at_last    = (beat == LAST_BEAT);
  // The final beat triggers a capture next cycle, so it may only enter when the
  // output register is empty or is being drained on this same edge.
  assign in_ready_c = (state == ACCUM) && (!at_last || !out_valid_q || bus.out_ready);
  assign accept     = bus.in_valid && in_ready_c;

`ifdef RS_SYN_FRAME_CHECK_EN
  assign frame_bad = accept && (bus.in_last != at_last);
`else
  logic unused_in_last;
  assign unused_in_last = bus.in_last;
  assign frame_bad      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACCUM;
      beat        <= '0;
      out_syn_q   <= '0;
      out_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_bad;
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state)
        ACCUM: begin
          if (accept) begin
            if (frame_bad) begin
              // Misframed beat is swallowed; restart at beat 0 without a capture.
              beat <= '0;
            end else if (at_last) begin
              beat  <= '0;
              state <= CAPT;
            end else begin
              beat <= beat + 4'd1;
            end
          end
        end
        CAPT: begin
          // Slices registered the final beat on the previous edge, so their
          // accumulators hold the complete syndromes now. Overrides any drain above.
          out_syn_q   <= bus.slc_syn;
          out_zero_q  <= (bus.slc_syn == '0);
          out_valid_q <= 1'b1;
          state       <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.slc_data  = bus.in_data;
  assign bus.slc_valid = accept;
  assign bus.slc_beat  = beat;
  assign bus.slc_first = (beat == 4'd0);
  assign bus.out_syn   = out_syn_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_valid = out_valid_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_rs_syndrome_ctrl.sv
module tb_rs_syndrome_ctrl;
  localparam int NSYN  = 16;
  localparam int BEATS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rs_syndrome_ctrl_if #(.NSYN(NSYN)) bus ();
  rs_syndrome_ctrl #(.NSYN(NSYN), .BEATS(BEATS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // GF(256), primitive polynomial x^8+x^4+x^3+x^2+1, alpha = 2.
  logic [7:0] alog [255];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1d) : (x << 1);
    end
    return r;
  endfunction

  // Contribution of codeword byte c at byte position pos to syndrome j: c * alpha^(j*pos).
  function automatic logic [7:0] term(input int j, input int pos, input logic [7:0] c);
    return gmul(c, alog[(j * pos) % 255]);
  endfunction

  // Reference: full syndrome vector of a 256-byte codeword, by direct polynomial evaluation.
  function automatic logic [127:0] ref_syn(input logic [127:0] cw [16]);
    logic [127:0] s = '0;
    for (int j = 0; j < NSYN; j++)
      for (int i = 0; i < 256; i++)
        s[8*j +: 8] ^= term(j, i, cw[i / 16][8*(i % 16) +: 8]);
    return s;
  endfunction

  // Slice array: each slice uses only the broadcast beat index to place bytes.
  logic [7:0] sacc [NSYN];

  function automatic logic [7:0] slice_next(input int j, input logic [7:0] old, input logic first,
                                            input logic [3:0] bt, input logic [127:0] d);
    logic [7:0] acc = first ? 8'h00 : old;
    for (int k = 0; k < 16; k++) acc ^= term(j, int'(bt) * 16 + k, d[8*k +: 8]);
    return acc;
  endfunction

  always @(posedge clk) begin
    if (bus.slc_valid)
      for (int j = 0; j < NSYN; j++)
        sacc[j] <= slice_next(j, sacc[j], bus.slc_first, bus.slc_beat, bus.slc_data);
  end

  always_comb begin
    bus.slc_syn = '0;
    for (int j = 0; j < NSYN; j++) bus.slc_syn[8*j +: 8] = sacc[j];
  end

  // out_ready: 0 / 1 / random per cycle.
  logic [1:0] or_mode = 2'd1;
  logic       or_rand = 1'b1;
  assign bus.out_ready = (or_mode == 2'd2) ? or_rand : or_mode[0];
  initial forever begin
    @(negedge clk);
    or_rand = ($urandom_range(0, 3) != 0);
  end

  // Scoreboard of expected vectors plus hold-stability monitor.
  logic [127:0] exp_q [$];
  initial begin : monitor
    logic         hold_v;
    logic [127:0] hold_syn;
    logic         hold_z;
    logic [127:0] e;
    hold_v = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check1("hold_valid", bus.out_valid, 1'b1);
          check("hold_syn", bus.out_syn, hold_syn);
          check1("hold_zero", bus.out_zero, hold_z);
        end
        hold_v   = bus.out_valid && !bus.out_ready;
        hold_syn = bus.out_syn;
        hold_z   = bus.out_zero;
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_vector: got %h expected none", bus.out_syn);
          end else begin
            e = exp_q.pop_front();
            check("sb_syn", bus.out_syn, e);
            check1("sb_zero", bus.out_zero, e == '0);
          end
        end
      end
    end
  end

  // Called just after a falling edge; returns just after the falling edge that follows acceptance.
  task automatic send_beat(input logic [127:0] d, input logic last, input int exp_idx);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    #1;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got in_ready=0 expected 1 within 200 cycles");
    end else begin
      check1("slc_valid", bus.slc_valid, 1'b1);
      check("slc_beat", 128'(bus.slc_beat), 128'(exp_idx));
      check1("slc_first", bus.slc_first, exp_idx == 0);
      check("slc_data", bus.slc_data, d);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_cw(input logic [127:0] cw [16], input int last_at, input bit gaps, input bit push);
    if (push) exp_q.push_back(ref_syn(cw));
    for (int i = 0; i < BEATS; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      send_beat(cw[i], i == last_at, i);
    end
  endtask

  task automatic gen_cw(output logic [127:0] cw [16]);
    int mode = $urandom_range(0, 3);
    for (int i = 0; i < BEATS; i++) cw[i] = '0;
    if (mode == 1 || mode == 2) begin
      repeat (mode) begin
        int p = $urandom_range(0, 255);
        cw[p / 16][8*(p % 16) +: 8] = 8'($urandom_range(1, 255));
      end
    end else if (mode == 3) begin
      for (int i = 0; i < BEATS; i++) cw[i] = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drain_empty", 128'(exp_q.size()), 128'd0);
  endtask

  typedef struct {
    int           pos1;
    logic [7:0]   val1;
    int           pos2;
    logic [7:0]   val2;
    logic [127:0] exp_syn;
    logic         exp_zero;
  } vec_t;

  vec_t         tbl [5];
  logic [127:0] cw  [16];
  logic [127:0] cwb [16];
  logic [127:0] ra;
  logic [127:0] rb;

  initial begin
    logic [7:0] x;
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      alog[i] = x;
      x = x[7] ? ((x << 1) ^ 8'h1d) : (x << 1);
    end

    tbl[0] = '{0, 8'h00, 0, 8'h00, 128'h0, 1'b1};
    tbl[1] = '{0, 8'h01, 0, 8'h00, {16{8'h01}}, 1'b0};
    tbl[2] = '{0, 8'h5a, 0, 8'h00, {16{8'h5a}}, 1'b0};
    tbl[3] = '{1, 8'h01, 0, 8'h00, 128'h261387cde8743a1d8040201008040201, 1'b0};
    tbl[4] = '{0, 8'h01, 1, 8'h01, 128'h271286cce9753b1c8141211109050300, 1'b0};

    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;

    // Reset values.
    repeat (3) @(negedge clk);
    #1;
    check1("rst_in_ready", bus.in_ready, 1'b1);
    check1("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_syn", bus.out_syn, 128'h0);
    check1("rst_out_zero", bus.out_zero, 1'b0);
    check1("rst_frame_err", bus.frame_err, 1'b0);
    check("rst_slc_beat", 128'(bus.slc_beat), 128'd0);
    check1("rst_slc_first", bus.slc_first, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Table: known syndromes, plus exact capture latency.
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < BEATS; i++) cw[i] = '0;
      cw[tbl[t].pos1 / 16][8*(tbl[t].pos1 % 16) +: 8] ^= tbl[t].val1;
      cw[tbl[t].pos2 / 16][8*(tbl[t].pos2 % 16) +: 8] ^= tbl[t].val2;
      send_cw(cw, 15, 0, 1);
      #1;
      check1("capt_valid_low", bus.out_valid, 1'b0);
      check1("capt_in_ready", bus.in_ready, 1'b0);
      @(negedge clk);
      #1;
      check1("tbl_valid", bus.out_valid, 1'b1);
      check("tbl_syn", bus.out_syn, tbl[t].exp_syn);
      check1("tbl_zero", bus.out_zero, tbl[t].exp_zero);
    end
    drain();

    // Back-to-back with output blocked: final beat of B stalls until release.
    or_mode = 2'd0;
    gen_cw(cw);
    gen_cw(cwb);
    cw[3][7:0] = 8'h77;
    ra = ref_syn(cw);
    rb = ref_syn(cwb);
    send_cw(cw, 15, 0, 1);
    exp_q.push_back(rb);
    for (int i = 0; i < BEATS - 1; i++) send_beat(cwb[i], 1'b0, i);
    bus.in_valid = 1'b1;
    bus.in_data  = cwb[15];
    bus.in_last  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check1("stall_in_ready", bus.in_ready, 1'b0);
      check1("stall_out_valid", bus.out_valid, 1'b1);
      check("stall_out_syn", bus.out_syn, ra);
      @(negedge clk);
    end
    or_mode = 2'd1;
    #1;
    check1("release_in_ready", bus.in_ready, 1'b1);
    check("release_beat", 128'(bus.slc_beat), 128'd15);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    #1;
    check1("release_capt", bus.out_valid, 1'b0);
    @(negedge clk);
    #1;
    check1("second_valid", bus.out_valid, 1'b1);
    check("second_syn", bus.out_syn, rb);
    drain();

    // Reset mid-codeword with a held vector pending.
    or_mode = 2'd0;
    gen_cw(cw);
    send_cw(cw, 15, 0, 0);
    for (int i = 0; i < 8; i++) send_beat({4{$urandom}}, 1'b0, i);
    #1;
    check1("pre_rst_valid", bus.out_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check1("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_out_syn", bus.out_syn, 128'h0);
    check1("mid_rst_out_zero", bus.out_zero, 1'b0);
    check1("mid_rst_in_ready", bus.in_ready, 1'b1);
    check("mid_rst_beat", 128'(bus.slc_beat), 128'd0);
    rst     = 1'b0;
    or_mode = 2'd1;
    for (int i = 0; i < BEATS; i++) cw[i] = '0;
    cw[5][8*3 +: 8] = 8'hc3;
    send_cw(cw, 15, 0, 1);
    drain();

    // in_last on beat 9.
    gen_cw(cw);
`ifdef RS_SYN_FRAME_CHECK_EN
    for (int i = 0; i < 10; i++) send_beat(cw[i], i == 9, i);
    #1;
    check1("frame_err_pulse", bus.frame_err, 1'b1);
    @(negedge clk);
    #1;
    check1("frame_err_clear", bus.frame_err, 1'b0);
    check1("frame_no_valid", bus.out_valid, 1'b0);
    check("frame_beat_restart", 128'(bus.slc_beat), 128'd0);
    gen_cw(cw);
    send_cw(cw, 15, 0, 1);
`else
    exp_q.push_back(ref_syn(cw));
    for (int i = 0; i < BEATS; i++) begin
      send_beat(cw[i], i == 9, i);
      if (i == 9) begin
        #1;
        check1("no_frame_err", bus.frame_err, 1'b0);
      end
    end
`endif
    drain();

    // Randomized traffic with gaps and random output backpressure.
    or_mode = 2'd2;
    for (int n = 0; n < 24; n++) begin
      gen_cw(cw);
      send_cw(cw, 15, 1, 1);
    end
    or_mode = 2'd1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
